mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 119 +++++++++++
 tb/tb_mul_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq
// Description : Sequential shift-add multiplier, one multiplier bit per cycle,
//               MSB first, with optional two's-complement operand mode.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 signed_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int              c_PW     = 2 * WIDTH;
    localparam int              c_CW     = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(WIDTH - 1);
    localparam logic            c_SIGNED = (SIGNED_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_mag_a;
    logic [WIDTH-1:0]  r_mag_b;
    logic              r_neg;
    logic [c_PW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [c_PW-1:0]   r_p;

    logic              w_accept;
    logic              w_last;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [WIDTH-1:0]  w_mag_a_in;
    logic [WIDTH-1:0]  w_mag_b_in;
    logic [c_PW-1:0]   w_addend;
    logic [c_PW-1:0]   w_acc_nxt;
    logic [c_PW-1:0]   w_result;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

    // Signed operands are reduced to magnitudes; the most-negative value maps
    // to 2**(WIDTH-1), which still fits the unsigned WIDTH-bit magnitude.
    assign w_signed   = signed_i & c_SIGNED;
    assign w_a_neg    = w_signed & a_i[WIDTH-1];
    assign w_b_neg    = w_signed & b_i[WIDTH-1];
    assign w_mag_a_in = w_a_neg ? (~a_i + WIDTH'(1)) : a_i;
    assign w_mag_b_in = w_b_neg ? (~b_i + WIDTH'(1)) : b_i;

    assign w_addend  = r_mag_b[WIDTH-1] ? {{WIDTH{1'b0}}, r_mag_a} : '0;
    assign w_acc_nxt = {r_acc[c_PW-2:0], 1'b0} + w_addend;
    assign w_result  = r_neg ? (~w_acc_nxt + c_PW'(1)) : w_acc_nxt;

    assign p_o = r_p;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mag_a <= w_mag_a_in;
                r_mag_b <= w_mag_b_in;
                r_neg   <= w_a_neg ^ w_b_neg;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                // Multiplier shifts left so its MSB is always the bit in play.
                r_acc   <= w_acc_nxt;
                r_mag_b <= {r_mag_b[WIDTH-2:0], 1'b0};
                r_cnt   <= r_cnt + c_CW'(1);
                if (w_last) r_p <= w_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq
// Description : Scoreboard bench for mul_seq (8-bit signed-capable instance and
//               16-bit unsigned-only instance sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        r_start8;
    logic [7:0]  r_a8;
    logic [7:0]  r_b8;
    logic        r_sg8;
    logic        w_busy8;
    logic        w_done8;
    logic [15:0] w_p8;

    logic        r_start16;
    logic [15:0] r_a16;
    logic [15:0] r_b16;
    logic        r_sg16;
    logic        w_busy16;
    logic        w_done16;
    logic [31:0] w_p16;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];
    logic [15:0] last8;

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_start8),
        .a_i      (r_a8),
        .b_i      (r_b8),
        .signed_i (r_sg8),
        .busy     (w_busy8),
        .done     (w_done8),
        .p_o      (w_p8)
    );

    mul_seq #(.WIDTH(16), .SIGNED_EN(0)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_start16),
        .a_i      (r_a16),
        .b_i      (r_b16),
        .signed_i (r_sg16),
        .busy     (w_busy16),
        .done     (w_done16),
        .p_o      (w_p16)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference: sign-extend from w bits, multiply, truncate to 2w.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    always @(negedge clk) begin
        if (w_busy8 && w_done8)   check_val("overlap8", 1, 0);
        if (w_busy16 && w_done16) check_val("overlap16", 1, 0);
        if (w_done8) begin
            if (q8.size() == 0) check_val("spurious_done8", 1, 0);
            else                check_val("p8", w_p8, q8.pop_front());
        end
        if (w_done16) begin
            if (q16.size() == 0) check_val("spurious_done16", 1, 0);
            else                 check_val("p16", w_p16, q16.pop_front());
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp);
        @(negedge clk);
        r_start8 = 1'b1; r_a8 = a; r_b8 = b; r_sg8 = s;
        q8.push_back(exp);
        @(posedge clk);
        #1;
        r_start8 = 1'b0;
        r_a8 = 8'($urandom); r_b8 = 8'($urandom); r_sg8 = ~s;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check_val("busy8", {w_busy8, w_done8}, 2'b10);
            if (i == 3) check_val("p_hold_run8", w_p8, last8);
        end
        @(posedge clk); #1;
        check_val("done8_latency", {w_busy8, w_done8}, 2'b01);
        @(posedge clk); #1;
        check_val("idle8", {w_busy8, w_done8}, 2'b00);
        last8 = exp;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        r_start8 = 1'b0;  r_a8 = '0;  r_b8 = '0;  r_sg8 = 1'b0;
        r_start16 = 1'b0; r_a16 = '0; r_b16 = '0; r_sg16 = 1'b0;
        last8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state8", {w_busy8, w_done8, w_p8}, 0);
        check_val("rst_state16", {w_busy16, w_done16, w_p16}, 0);
        rst_n = 1'b1;

        // Directed vectors
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        repeat (3) @(posedge clk);
        #1 check_val("p_hold_idle8", w_p8, 16'hFE01);
        op8(8'h80, 8'h80, 1'b1, 16'h4000);
        op8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        op8(8'hFD, 8'h05, 1'b0, 16'h04F1);
        op8(8'h7F, 8'h80, 1'b1, 16'hC080);
        op8(8'h00, 8'hAB, 1'b1, 16'h0000);
        op8(8'hAB, 8'h00, 1'b0, 16'h0000);

        // Start during RUN must be ignored
        @(negedge clk);
        r_start8 = 1'b1; r_a8 = 8'd3; r_b8 = 8'd4; r_sg8 = 1'b0;
        q8.push_back(16'd12);
        @(posedge clk); #1 r_start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r_start8 = 1'b1; r_a8 = 8'd9; r_b8 = 8'd9;
        @(posedge clk); #1 r_start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_val("ign_busy_e7", {w_busy8, w_done8}, 2'b10);
        @(posedge clk); #1 check_val("ign_done_e8", {w_busy8, w_done8}, 2'b01);
        @(posedge clk); #1 check_val("ign_idle_e9", {w_busy8, w_done8}, 2'b00);
        repeat (12) @(posedge clk);
        last8 = 16'd12;

        // Asynchronous reset mid-run aborts without a done pulse
        @(negedge clk);
        r_start8 = 1'b1; r_a8 = 8'd7; r_b8 = 8'd7; r_sg8 = 1'b0;
        @(posedge clk); #1 r_start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_val("abort_async", {w_busy8, w_done8, w_p8}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last8 = '0;
        repeat (12) @(posedge clk);
        #1 check_val("abort_p", w_p8, 0);
        op8(8'd2, 8'd3, 1'b0, 16'd6);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        r_start8 = 1'b1; r_a8 = 8'd10; r_b8 = 8'd10; r_sg8 = 1'b0;
        q8.push_back(16'd100);
        q8.push_back(16'd100);
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 check_val("b2b_busy_e7", {w_busy8, w_done8}, 2'b10);
        @(posedge clk); #1 check_val("b2b_done_e8", {w_busy8, w_done8}, 2'b01);
        @(posedge clk); #1 check_val("b2b_busy_e9", {w_busy8, w_done8}, 2'b10);
        r_start8 = 1'b0;
        repeat (7) @(posedge clk);
        #1 check_val("b2b_busy_e16", {w_busy8, w_done8}, 2'b10);
        @(posedge clk); #1 check_val("b2b_done_e17", {w_busy8, w_done8}, 2'b01);
        @(posedge clk); #1 check_val("b2b_idle_e18", {w_busy8, w_done8}, 2'b00);
        last8 = 16'd100;

        // Random signed/unsigned pairs on the 8-bit instance
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            op8(ra, rb, rs, 16'(ref_mul(8, {8'h00, ra}, {8'h00, rb}, rs)));
        end

        // Random unsigned-only instance; signed_i toggles and must not matter
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r_start16 = 1'b1;
            r_a16 = 16'($urandom);
            r_b16 = 16'($urandom);
            r_sg16 = 1'($urandom_range(0, 1));
            q16.push_back(ref_mul(16, r_a16, r_b16, 1'b0));
            @(posedge clk); #1 r_start16 = 1'b0;
            repeat (16) @(posedge clk);
            #1 check_val("done16_latency", w_done16, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        check_val("q8_empty", q8.size(), 0);
        check_val("q16_empty", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
